// File: rtl/hazard_flush_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_flush_ctrl (slave).
interface hazard_flush_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rd;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             ex_br_valid;
  logic             ex_br_mispredict;
  logic             id_btb_hit;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             hit;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rs, if_id_rt,
           ex_br_valid, ex_br_mispredict, id_btb_hit,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, hit,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rs, if_id_rt,
           ex_br_valid, ex_br_mispredict, id_btb_hit,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, hit,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall / mispredict flush sequencer for the 5-stage pipeline.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush event counters.
module hazard_flush_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_flush_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t           state_q;
  logic [1:0]       flush_left;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             lu;
  logic             mp;

  assign ex_rd = bus.id_ex_rd;
  assign id_rs = bus.if_id_rs;
  assign id_rt = bus.if_id_rt;

  assign lu = bus.id_ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign mp = bus.ex_br_valid && bus.ex_br_mispredict;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      flush_left <= 2'd0;
    end else if (mp) begin
      if (FLUSH_CYCLES > 1) begin
        state_q    <= FLUSH;
        flush_left <= FLUSH_RELOAD;
      end else begin
        state_q    <= RUN;
        flush_left <= 2'd0;
      end
    end else begin
      case (state_q)
        RUN:   if (lu) state_q <= STALL;
        STALL: state_q <= RUN;
        FLUSH: begin
          if (flush_left != 2'd0) flush_left <= flush_left - 2'd1;
          if (flush_left <= 2'd1) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.hit         = bus.id_btb_hit;
    if (rst) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
      bus.hit         = 1'b0;
    end else if (mp || state_q == FLUSH) begin
      // Wrong-path BTB hits inside the window must not override the flush mux.
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
      bus.hit         = 1'b0;
    end else if (state_q == RUN && lu) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_flush = 1'b1;
      bus.hit         = 1'b0;
    end
  end

  assign bus.state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             stall_ev;

  assign stall_ev = !mp && (state_q == RUN) && lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (mp && flush_q != '1)       flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: a FLUSH_CYCLES=2/CNT_W=16 and a FLUSH_CYCLES=3/CNT_W=2 instance driven in lockstep.
module tb_hazard_flush_ctrl;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       bv;
    logic       bm;
    logic       btb;
  } in_t;

  // Output bundle layout: {pc_write, if_id_write, if_id_flush, id_ex_flush, hit, state[1:0]}
  typedef struct packed {
    in_t        in;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_RUNH  = 7'b1100100;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_FLUSH = 7'b1111000;
  localparam logic [6:0] O_RESET = 7'b0011000;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_flush_ctrl_if #(.REG_W(5), .CNT_W(16)) if2 ();
  hazard_flush_ctrl_if #(.REG_W(5), .CNT_W(2))  if3 ();

  hazard_flush_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));
  hazard_flush_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: remaining flush cycles, whether a bubble was just inserted, event counts.
  int flush_rem[2];
  bit just_stalled[2];
  int scnt[2];
  int fcnt[2];
  int fc[2]   = '{2, 3};
  int cmax[2] = '{65535, 3};

  logic [6:0]  act_o[2];
  logic [15:0] act_s[2];
  logic [15:0] act_f[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cexp(input int v);
`ifdef HAZ_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic bit is_lu(input in_t x);
    return x.mr && x.rd != 0 && (x.rd == x.rs || x.rd == x.rt);
  endfunction

  function automatic logic [6:0] model_out(input int d, input in_t x);
    logic [1:0] st;
    st = (flush_rem[d] > 0) ? 2'd2 : (just_stalled[d] ? 2'd1 : 2'd0);
    if ((x.bv && x.bm) || flush_rem[d] > 0) return O_FLUSH | {5'b0, st};
    if (is_lu(x) && !just_stalled[d])        return O_STALL | {5'b0, st};
    return {4'b1100, x.btb, st};
  endfunction

  task automatic model_update(input int d, input in_t x);
    if (x.bv && x.bm) begin
      flush_rem[d]    = fc[d] - 1;
      just_stalled[d] = 1'b0;
      if (fcnt[d] < cmax[d]) fcnt[d]++;
    end else if (flush_rem[d] > 0) begin
      flush_rem[d]--;
    end else if (is_lu(x) && !just_stalled[d]) begin
      just_stalled[d] = 1'b1;
      if (scnt[d] < cmax[d]) scnt[d]++;
    end else begin
      just_stalled[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      flush_rem[d]    = 0;
      just_stalled[d] = 1'b0;
      scnt[d]         = 0;
      fcnt[d]         = 0;
    end
  endtask

  task automatic drive(input in_t x);
    if2.id_ex_mem_read = x.mr;  if3.id_ex_mem_read = x.mr;
    if2.id_ex_rd = x.rd;        if3.id_ex_rd = x.rd;
    if2.if_id_rs = x.rs;        if3.if_id_rs = x.rs;
    if2.if_id_rt = x.rt;        if3.if_id_rt = x.rt;
    if2.ex_br_valid = x.bv;     if3.ex_br_valid = x.bv;
    if2.ex_br_mispredict = x.bm; if3.ex_br_mispredict = x.bm;
    if2.id_btb_hit = x.btb;     if3.id_btb_hit = x.btb;
  endtask

  task automatic sample();
    act_o[0] = {if2.pc_write, if2.if_id_write, if2.if_id_flush, if2.id_ex_flush, if2.hit, if2.state};
    act_o[1] = {if3.pc_write, if3.if_id_write, if3.if_id_flush, if3.id_ex_flush, if3.hit, if3.state};
    act_s[0] = if2.stall_cnt;
    act_f[0] = if2.flush_cnt;
    act_s[1] = {14'd0, if3.stall_cnt};
    act_f[1] = {14'd0, if3.flush_cnt};
  endtask

  // Drive one cycle at posedge+1, compare against the model at the negedge, advance.
  task automatic step(input in_t x);
    drive(x);
    @(negedge clk);
    sample();
    for (int d = 0; d < 2; d++) begin
      check(d == 0 ? "model outputs fc2" : "model outputs fc3", 32'(act_o[d]), 32'(model_out(d, x)));
      check(d == 0 ? "model stall_cnt fc2" : "model stall_cnt fc3", 32'(act_s[d]), 32'(cexp(scnt[d])));
      check(d == 0 ? "model flush_cnt fc2" : "model flush_cnt fc3", 32'(act_f[d]), 32'(cexp(fcnt[d])));
      model_update(d, x);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mk(input logic mr, input int rd, input int rs, input int rt,
                             input logic bv, input logic bm, input logic btb);
    in_t x;
    x.mr = mr; x.rd = 5'(rd); x.rs = 5'(rs); x.rt = 5'(rt);
    x.bv = bv; x.bm = bm; x.btb = btb;
    return x;
  endfunction

  vec_t vecs[21];
  in_t  idle;
  in_t  lu5;
  in_t  mp_only;

  initial begin
    idle    = '0;
    lu5     = mk(1, 5, 0, 5, 0, 0, 0);
    mp_only = mk(0, 0, 0, 0, 1, 1, 0);

    vecs[0]  = '{idle,                       O_RUN};
    vecs[1]  = '{mk(0, 0, 0, 0, 0, 0, 1),    O_RUNH};
    vecs[2]  = '{lu5,                        O_STALL};
    vecs[3]  = '{lu5,                        O_RUN | 7'd1};
    vecs[4]  = '{idle,                       O_RUN};
    vecs[5]  = '{mk(1, 0, 0, 0, 0, 0, 0),    O_RUN};
    vecs[6]  = '{mk(1, 0, 0, 0, 0, 0, 0),    O_RUN};
    vecs[7]  = '{mk(0, 0, 0, 0, 1, 1, 1),    O_FLUSH};
    vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 1),    O_FLUSH | 7'd2};
    vecs[9]  = '{mk(0, 0, 0, 0, 0, 0, 1),    O_RUNH};
    vecs[10] = '{mk(1, 5, 5, 1, 1, 1, 0),    O_FLUSH};
    vecs[11] = '{mk(1, 5, 5, 1, 0, 0, 0),    O_FLUSH | 7'd2};
    vecs[12] = '{mk(1, 5, 5, 1, 0, 0, 0),    O_STALL};
    vecs[13] = '{mk(1, 5, 5, 1, 0, 0, 0),    O_RUN | 7'd1};
    vecs[14] = '{idle,                       O_RUN};
    vecs[15] = '{lu5,                        O_STALL};
    vecs[16] = '{mp_only,                    O_FLUSH | 7'd1};
    vecs[17] = '{idle,                       O_FLUSH | 7'd2};
    vecs[18] = '{idle,                       O_RUN};
    vecs[19] = '{mk(1, 3, 3, 0, 0, 0, 1),    O_STALL};
    vecs[20] = '{idle,                       O_RUN | 7'd1};

    // Power-on reset: outputs forced while rst is high.
    rst = 1'b1;
    drive(idle);
    model_reset();
    #2;
    sample();
    check("reset outputs fc2", 32'(act_o[0]), 32'(O_RESET));
    check("reset outputs fc3", 32'(act_o[1]), 32'(O_RESET));
    check("reset stall_cnt", 32'(act_s[0]), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].in);
      @(negedge clk);
      sample();
      check($sformatf("vector %0d fc2", i), 32'(act_o[0]), 32'(vecs[i].exp));
      @(posedge clk);
      // Rewind to the negedge-free point and let the model check the same cycle.
      #1;
      for (int d = 0; d < 2; d++) model_update(d, vecs[i].in);
    end
    check("table stall_cnt fc2", 32'(if2.stall_cnt), 32'(cexp(4)));
    check("table flush_cnt fc2", 32'(if2.flush_cnt), 32'(cexp(3)));

    // Reset pulse in the middle of a flush window aborts it at once.
    step(mp_only);
    drive(idle);
    #2 rst = 1'b1;
    #1;
    sample();
    check("midflush reset outputs fc2", 32'(act_o[0]), 32'(O_RESET));
    check("midflush reset outputs fc3", 32'(act_o[1]), 32'(O_RESET));
    check("midflush reset flush_cnt", 32'(act_f[0]), 32'd0);
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(idle);
    check("post reset run fc2", 32'(act_o[0]), 32'(O_RUN));
    check("post reset run fc3", 32'(act_o[1]), 32'(O_RUN));

    // FLUSH_CYCLES=3: a second mispredict in the 2nd flush cycle gives 4 flush cycles.
    step(mp_only);  check("retrigger c0", 32'(act_o[1]), 32'(O_FLUSH));
    step(mp_only);  check("retrigger c1", 32'(act_o[1]), 32'(O_FLUSH | 7'd2));
    step(idle);     check("retrigger c2", 32'(act_o[1]), 32'(O_FLUSH | 7'd2));
    step(idle);     check("retrigger c3", 32'(act_o[1]), 32'(O_FLUSH | 7'd2));
    step(idle);     check("retrigger c4", 32'(act_o[1]), 32'(O_RUN));
    check("retrigger flush_cnt fc3", 32'(if3.flush_cnt), 32'(cexp(2)));

    // Five separate load-use bubbles saturate the 2-bit counter at 3.
    for (int k = 0; k < 5; k++) begin
      step(lu5);
      step(idle);
    end
    check("saturated stall_cnt fc3", 32'(if3.stall_cnt), 32'(cexp(3)));
    check("stall_cnt fc2 after 5", 32'(if2.stall_cnt), 32'(cexp(5)));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      in_t x;
      x.mr  = 1'($urandom_range(0, 1));
      x.rd  = 5'($urandom_range(0, 3));
      x.rs  = 5'($urandom_range(0, 3));
      x.rt  = 5'($urandom_range(0, 3));
      x.bv  = ($urandom_range(0, 2) == 0);
      x.bm  = 1'($urandom_range(0, 1));
      x.btb = 1'($urandom_range(0, 1));
      step(x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
